// File: rtl/conv_frame_mem.sv
// Frame buffer around a convolution engine: loads an input image, serves engine reads/writes, drains results.
// Optional build macro FRAME_MEM_BOUNDS_CHK_EN adds address range checking and a sticky err flag.
module conv_frame_mem #(
  parameter int DW    = 12,
  parameter int AW    = 17,
  parameter int DEPTH = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          start,
  input  logic [AW-1:0] addr_rd,
  output logic [DW-1:0] d_in,
  input  logic          wr_en,
  input  logic [AW-1:0] addr_wr,
  input  logic [DW-1:0] d_out,
  input  logic          conv_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ld_cnt_q, ld_cnt_d;
  logic [IW-1:0] dr_idx_q, dr_idx_d;
  logic [IW-1:0] dr_nxt;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic [DW-1:0] m_data_q, m_data_d;

  logic [DW-1:0] in_mem  [DEPTH];
  logic [DW-1:0] res_mem [DEPTH];

  logic          in_we, res_we;
  logic [IW-1:0] rd_idx, wr_idx;
  logic          rd_oob, wr_oob;

  assign rd_idx = addr_rd[IW-1:0];
  assign wr_idx = addr_wr[IW-1:0];
  assign dr_nxt = dr_idx_q + IW'(1);

`ifdef FRAME_MEM_BOUNDS_CHK_EN
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  logic err_q, err_d;

  assign rd_oob = (addr_rd >= DEPTH_A);
  assign wr_oob = (addr_wr >= DEPTH_A);

  // Engine addresses only carry meaning in RUN; elsewhere addr_rd may be idle garbage.
  always_comb begin
    err_d = err_q | ((state_q == RUN) && (rd_oob || (wr_en && wr_oob)));
  end

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_addr_bits;

  assign rd_oob           = 1'b0;
  assign wr_oob           = 1'b0;
  assign unused_addr_bits = ^{addr_rd[AW-1:IW], addr_wr[AW-1:IW]};
  assign err              = 1'b0;
`endif

  // Combinational so the engine can prefetch in any state.
  assign d_in = rd_oob ? '0 : in_mem[rd_idx];

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    dr_idx_d  = dr_idx_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    in_we     = 1'b0;
    res_we    = 1'b0;
    ld_ready  = 1'b0;
    start     = 1'b0;

    case (state_q)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          in_we = 1'b1;
          if (ld_cnt_q == LAST_IDX) begin
            ld_cnt_d = '0;
            state_d  = RUN;
          end else begin
            ld_cnt_d = ld_cnt_q + IW'(1);
          end
        end
      end

      RUN: begin
        start  = 1'b1;
        res_we = wr_en && !wr_oob;
        if (conv_ready) state_d = DRAIN;
      end

      DRAIN: begin
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = res_mem[dr_idx_q];
          m_last_d  = (dr_idx_q == LAST_IDX);
        end else if (m_ready) begin
          if (m_last_q) begin
            state_d   = LOAD;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            dr_idx_d  = '0;
            ld_cnt_d  = '0;
          end else begin
            dr_idx_d = dr_nxt;
            m_data_d = res_mem[dr_nxt];
            m_last_d = (dr_nxt == LAST_IDX);
          end
        end
      end

      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= LOAD;
      ld_cnt_q  <= '0;
      dr_idx_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      dr_idx_q  <= dr_idx_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  // NOTE: the memories have no reset; contents survive a mid-frame reset, only writes are blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (in_we)  in_mem[ld_cnt_q] <= ld_data;
      if (res_we) res_mem[wr_idx]  <= d_out;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_conv_frame_mem.sv
// Self-checking bench for conv_frame_mem: vector table for the RUN phase, scoreboard for the drain stream.
module tb_conv_frame_mem;

  localparam int DW    = 12;
  localparam int AW    = 17;
  localparam int DEPTH = 25;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          start;
  logic [AW-1:0] addr_rd = '0;
  logic [DW-1:0] d_in;
  logic          wr_en = 1'b0;
  logic [AW-1:0] addr_wr = '0;
  logic [DW-1:0] d_out = '0;
  logic          conv_ready = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          err;

  conv_frame_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .start      (start),
    .addr_rd    (addr_rd),
    .d_in       (d_in),
    .wr_en      (wr_en),
    .addr_wr    (addr_wr),
    .d_out      (d_out),
    .conv_ready (conv_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd_addr;
    int exp_d_in;
    bit wr;
    int wr_addr;
    int wr_data;
  } vec_t;

  vec_t tbl [DEPTH];
  int   in_model  [DEPTH];
  int   res_model [DEPTH];
  int   sb [$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads base+i at address i with ld_valid held high; poke drives engine strobes that LOAD must ignore.
  task automatic load_frame(input int base, input bit poke);
    ld_valid = 1'b1;
    if (poke) begin
      wr_en      = 1'b1;
      addr_wr    = AW'(5);
      d_out      = 12'h777;
      conv_ready = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      ld_data     = DW'(base + i);
      in_model[i] = base + i;
      @(negedge clk);
      check("ld_ready_in_load", 32'(ld_ready), 32'd1);
      if (i == 0) check("start_in_load", 32'(start), 32'd0);
      step();
      wr_en      = 1'b0;
      conv_ready = 1'b0;
    end
    ld_data = '1;
    @(negedge clk);
    check("ld_ready_after_last", 32'(ld_ready), 32'd0);
    check("start_after_load", 32'(start), 32'd1);
    step();
    ld_valid = 1'b0;
  endtask

  task automatic run_frame(input int res_base, input bit do_wr);
    for (int i = 0; i < DEPTH; i++) begin
      int r;
      r      = (i * 7) % DEPTH;
      tbl[i] = '{rd_addr: r, exp_d_in: in_model[r], wr: do_wr, wr_addr: i, wr_data: res_base + i};
    end
    for (int i = 0; i < DEPTH; i++) begin
      addr_rd = AW'(tbl[i].rd_addr);
      wr_en   = tbl[i].wr;
      addr_wr = AW'(tbl[i].wr_addr);
      d_out   = DW'(tbl[i].wr_data);
      if (tbl[i].wr) res_model[tbl[i].wr_addr] = tbl[i].wr_data;
      @(negedge clk);
      check("d_in_run", 32'(d_in), 32'(tbl[i].exp_d_in));
      if (i == 0) check("start_in_run", 32'(start), 32'd1);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic finish_run(input bit combo);
    conv_ready = 1'b1;
    if (combo) begin
      wr_en         = 1'b1;
      addr_wr       = AW'(24);
      d_out         = 12'hABC;
      res_model[24] = 12'hABC;
    end
    for (int i = 0; i < DEPTH; i++) sb.push_back(res_model[i]);
    step();
    conv_ready = 1'b0;
    wr_en      = 1'b0;
    @(negedge clk);
    check("m_valid_at_drain_entry", 32'(m_valid), 32'd0);
    check("start_in_drain", 32'(start), 32'd0);
  endtask

  task automatic drain_frame(input bit stall, input int nwords);
    int            idx = 0;
    int            cyc = 0;
    bit            was_stall = 1'b0;
    logic [DW-1:0] held = '0;
    bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (idx < nwords && cyc < 400) begin
      step();
      m_ready = stall ? pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (cyc == 0) check("m_valid_rise", 32'(m_valid), 32'd1);
      if (was_stall) begin
        check("stall_valid_hold", 32'(m_valid), 32'd1);
        check("stall_data_hold", 32'(m_data), 32'(held));
        was_stall = 1'b0;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL sb_underflow: word %0d produced with no expected value queued", idx);
        end else begin
          int exp;
          exp = sb.pop_front();
          check("drain_data", 32'(m_data), 32'(exp));
        end
        check("drain_last", 32'(m_last), 32'(idx == DEPTH - 1));
        idx++;
      end else if (m_valid) begin
        held      = m_data;
        was_stall = 1'b1;
      end
      cyc++;
    end
    if (idx < nwords) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain_timeout: got %0d words, expected %0d", idx, nwords);
    end
    step();
    m_ready = 1'b0;
  endtask

  task automatic post_drain_checks();
    @(negedge clk);
    check("m_valid_after_drain", 32'(m_valid), 32'd0);
    check("ld_ready_after_drain", 32'(ld_ready), 32'd1);
    check("m_last_after_drain", 32'(m_last), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_start", 32'(start), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    step();
    rst = 1'b1;

    // Frame A: results addr+100, drain with 1,0,0,1 backpressure
    load_frame(0, 1'b0);
    run_frame(100, 1'b1);
    finish_run(1'b0);
    drain_frame(1'b1, DEPTH);
    post_drain_checks();

    // Frame B: reset while word 10 is presented
    step();
    load_frame(50, 1'b0);
    run_frame(200, 1'b1);
    finish_run(1'b0);
    drain_frame(1'b0, 10);
    @(negedge clk);
    check("word10_valid", 32'(m_valid), 32'd1);
    check("word10_data", 32'(m_data), 32'(sb[0]));
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_ld_ready", 32'(ld_ready), 32'd1);
    check("abort_start", 32'(start), 32'd0);
    check("abort_m_last", 32'(m_last), 32'd0);
    sb.delete();
    addr_rd = AW'(7);
    #1;
    check("d_in_kept_after_reset", 32'(d_in), 32'(in_model[7]));

    // Frame C: reload, rerun without rewriting, final write merged with conv_ready
    step();
    load_frame(0, 1'b1);
    run_frame(300, 1'b0);
`ifdef FRAME_MEM_BOUNDS_CHK_EN
    addr_rd = AW'(30);
    @(negedge clk);
    check("d_in_oob", 32'(d_in), 32'd0);
    step();
    addr_rd = AW'(0);
    wr_en   = 1'b1;
    addr_wr = AW'(40);
    d_out   = 12'h555;
    @(negedge clk);
    check("err_set", 32'(err), 32'd1);
    step();
    wr_en = 1'b0;
`else
    @(negedge clk);
    check("err_tied_low", 32'(err), 32'd0);
    step();
`endif
    finish_run(1'b1);
    drain_frame(1'b0, DEPTH);
    post_drain_checks();
`ifdef FRAME_MEM_BOUNDS_CHK_EN
    check("err_sticky", 32'(err), 32'd1);
`else
    check("err_still_low", 32'(err), 32'd0);
`endif
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("err_cleared_by_reset", 32'(err), 32'd0);
    check("final_ld_ready", 32'(ld_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_frame_mem.md
CONV_FRAME_MEM -- requirements
Module: conv_frame_mem

Interface
REQ-001 SHALL have parameter DW, default 12, pixel width.
REQ-002 SHALL have parameter AW, default 17, address width.
REQ-003 SHALL have parameter DEPTH, default 25, number of input-image words and of result words.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port ld_valid, input, 1, input-image load word valid.
REQ-007 SHALL have port ld_data, input, DW, input-image load word.
REQ-008 SHALL have port ld_ready, output, 1, load word accepted when high together with ld_valid.
REQ-009 SHALL have port start, output, 1, level start to the convolution engine.
REQ-010 SHALL have port addr_rd, input, AW, engine pixel read address.
REQ-011 SHALL have port d_in, output, DW, pixel data to the engine, combinational from addr_rd.
REQ-012 SHALL have port wr_en, input, 1, engine result write strobe.
REQ-013 SHALL have port addr_wr, input, AW, engine result write address.
REQ-014 SHALL have port d_out, input, DW, engine result data.
REQ-015 SHALL have port conv_ready, input, 1, engine frame-complete indication.
REQ-016 SHALL have ports m_valid (output, 1), m_data (output, DW), m_last (output, 1) and m_ready (input, 1), forming the result drain stream.
REQ-017 SHALL have port err, output, 1, sticky address-range error.

Function
REQ-018 SHALL implement states LOAD, RUN and DRAIN; the reset state is LOAD.
- LOAD: ld_ready=1; each ld_valid&&ld_ready writes ld_data to input memory at load count, then increments the count; the handshake at count DEPTH-1 moves the state to RUN on the next cycle.
- RUN: start=1; d_in=input memory[addr_rd] with zero latency; wr_en writes d_out to result memory[addr_wr] on the same edge; conv_ready moves the state to DRAIN.
- DRAIN: streams result words 0..DEPTH-1 in order; m_last=1 on word DEPTH-1 only; the handshake on the last word moves the state to LOAD and clears all counters.
REQ-019 SHALL assert start only in RUN, and ld_ready only in LOAD.
REQ-020 SHALL ignore ld_valid outside LOAD, and wr_en/conv_ready outside RUN.
REQ-021 SHALL commit a write when wr_en and conv_ready are high in the same cycle, before entering DRAIN.
REQ-022 SHALL register m_data from result memory, with m_valid rising 1 cycle after DRAIN entry.
REQ-023 SHALL hold m_valid and m_data stable while m_ready=0; a handshake with m_ready=1 presents the next word on the following cycle, for a sustained throughput of 1 word/cycle.
REQ-024 SHALL drive d_in as a pure function of addr_rd in every state, so the engine may prefetch.

Reset
REQ-025 SHALL, when rst=0 at a rising edge, force state LOAD, clear counters, and set start=0, m_valid=0, m_last=0, m_data=0, err=0 and ld_ready=1 on the next cycle.
REQ-026 SHALL, on a reset mid-operation (any state), abandon the frame, preserve memory contents, and not reset the memories.

Configuration
REQ-027 SHALL, with FRAME_MEM_BOUNDS_CHK_EN defined, return d_in=0 when addr_rd>=DEPTH, drop writes with addr_wr>=DEPTH, and set err sticky until reset.
REQ-028 SHALL, without FRAME_MEM_BOUNDS_CHK_EN, index both memories with unchecked truncated addresses and tie err to 0.

Verification
REQ-029 SHALL cover: load 25 words 0..24 with ld_valid held high -> ld_ready drops after the 25th; start=1 on the next cycle; d_in=addr_rd for addr_rd=0..24.
REQ-030 SHALL cover: in RUN, engine writes d_out=addr_wr+100 for addresses 0..24, then conv_ready -> drain emits 100..124 in order, with m_last only on 124.
REQ-031 SHALL cover: m_ready toggling 1,0,0,1 during DRAIN -> m_data held across the stall and no word lost or duplicated.
REQ-032 SHALL cover: wr_en to address 24 with d_out=0xABC in the same cycle as conv_ready -> last drained word is 0xABC.
REQ-033 SHALL cover: rst=0 for one cycle at drain word 10 -> state LOAD, m_valid=0, ld_ready=1; a reload followed by a rerun of the frame drains from word 0.
REQ-034 SHALL cover: with FRAME_MEM_BOUNDS_CHK_EN defined, addr_rd=30 -> d_in=0 and err=1; wr_en at addr_wr=40 -> no memory change; err stays 1 until reset.
